pipe_skid_stage: RTL and testbench

- Parametrised, multi-lane pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Next generation of the decode→execute stage register; also used between any two stages of the dual-issue pipeline.
- Replaces the stall-vector interface with per-stage backpressure: in_ready/out_ready.
- Keeps synchronous flush with NOP (all-zero) insertion.
- A bundle holds up to LANES instructions and moves as one unit; order is always preserved.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/skid_entry.sv | 29 ++
 rtl/pipe_skid_stage.sv | 125 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: lane geometry, per-boundary lane structs,
// the NOP encoding and the stage occupancy encoding.
package pipe_pkg;

  localparam int LANES_DEF     = 2;
  localparam int PAYLOAD_W_DEF = 160;

  // One decode->execute lane; the field widths add up to PAYLOAD_W_DEF.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [14:0] excepttype;
  } id_ex_lane_t;

  localparam id_ex_lane_t ID_EX_NOP = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_entry.sv
// One bundle register (per-lane valid mask plus payload) with
// load, valid-clear and payload-clear controls.
module skid_entry #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 160
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_vld,
  input  logic                         clr_data,
  input  logic                         load,
  input  logic [LANES-1:0]             d_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   d_payload,
  output logic [LANES-1:0]             valid,
  output logic [LANES*PAYLOAD_W-1:0]   payload
);

  always_ff @(posedge clk) begin
    if (rst)          valid <= '0;
    else if (clr_vld) valid <= '0;
    else if (load)    valid <= d_valid;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_data) payload <= '0;
    else if (load)       payload <= d_payload;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Multi-lane pipeline stage register with valid/ready handshake and a
// two-entry skid buffer; in_ready depends only on registered state.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int LANES          = LANES_DEF,
  parameter int PAYLOAD_W      = PAYLOAD_W_DEF,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload,
  input  logic                         out_ready,
  output logic [1:0]                   occupancy
);

  occ_e state, state_nxt;

  logic in_fire, out_fire;
  logic main_load, main_sel_skid, main_drop;
  logic skid_load, skid_drop;
  logic clr_data;

  logic [LANES-1:0]           main_valid, skid_valid, main_d_valid;
  logic [LANES*PAYLOAD_W-1:0] main_payload, skid_payload, main_d_payload;

  assign in_ready  = (state != OCC_TWO);
  assign in_fire   = in_ready & (|in_valid);
  assign out_fire  = out_ready & (|main_valid);
  assign occupancy = state;
  assign clr_data  = flush & CLEAR_ON_FLUSH;

  always_ff @(posedge clk) begin
    if (rst) state <= OCC_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    main_drop     = 1'b0;
    skid_load     = 1'b0;
    skid_drop     = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_nxt = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_nxt = OCC_TWO;
        end else if (out_fire) begin
          main_drop = 1'b1;
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // Input side is blocked here, so only a drain can move state.
        if (out_fire) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_drop     = 1'b1;
          state_nxt     = OCC_ONE;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
    if (flush) begin
      state_nxt     = OCC_EMPTY;
      main_load     = 1'b0;
      main_sel_skid = 1'b0;
      main_drop     = 1'b0;
      skid_load     = 1'b0;
      skid_drop     = 1'b0;
    end
  end

  assign main_d_valid   = main_sel_skid ? skid_valid   : in_valid;
  assign main_d_payload = main_sel_skid ? skid_payload : in_payload;

  skid_entry #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clr_vld   (flush | main_drop),
    .clr_data  (clr_data),
    .load      (main_load),
    .d_valid   (main_d_valid),
    .d_payload (main_d_payload),
    .valid     (main_valid),
    .payload   (main_payload)
  );

  skid_entry #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr_vld   (flush | skid_drop),
    .clr_data  (clr_data),
    .load      (skid_load),
    .d_valid   (in_valid),
    .d_payload (in_payload),
    .valid     (skid_valid),
    .payload   (skid_payload)
  );

  // Output boundary: invalid lanes always present the NOP encoding.
  assign out_valid = main_valid;
  always_comb begin
    out_payload = '0;
    for (int i = 0; i < LANES; i++) begin
      if (main_valid[i]) out_payload[i*PAYLOAD_W +: PAYLOAD_W] = main_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized and directed bench for pipe_skid_stage against a queue-based
// model of the stage (a FIFO of at most two non-empty bundles).
module tb_pipe_skid_stage;

  localparam int LANES = 2;
  localparam int PW    = 160;
  localparam int BW    = LANES * PW;

  typedef struct {
    logic [LANES-1:0] m;
    logic [BW-1:0]    p;
  } bundle_t;

  logic             clk = 1'b0;
  logic             rst, flush, out_ready, in_ready;
  logic [LANES-1:0] in_valid, out_valid;
  logic [BW-1:0]    in_payload, out_payload;
  logic [1:0]       occupancy;

  bundle_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.LANES(LANES), .PAYLOAD_W(PW), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_payload  (in_payload),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_ready   (out_ready),
    .occupancy   (occupancy)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] bundle2(input logic [PW-1:0] l0, input logic [PW-1:0] l1);
    return {l1, l0};
  endfunction

  function automatic logic [PW-1:0] rnd_lane();
    logic [PW-1:0] r;
    for (int k = 0; k < PW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge,
  // then compare every output against the model.
  task automatic cycle(input string tag);
    bit               rdy, ofire;
    bundle_t          b;
    logic [LANES-1:0] em;
    logic [BW-1:0]    ep;
    rdy = (q.size() < 2);
    @(posedge clk);
    ofire = out_ready && (q.size() > 0);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (ofire) q.delete(0);
      if (rdy && (in_valid != '0)) begin
        b.m = in_valid;
        b.p = in_payload;
        q.push_back(b);
      end
    end
    #1;
    em = '0;
    ep = '0;
    if (q.size() > 0) begin
      em = q[0].m;
      for (int i = 0; i < LANES; i++)
        if (em[i]) ep[i*PW +: PW] = q[0].p[i*PW +: PW];
    end
    check({tag, "_valid"}, BW'(out_valid), BW'(em));
    check({tag, "_payload"}, out_payload, ep);
    check({tag, "_occ"}, BW'(occupancy), BW'(q.size()));
    check({tag, "_ready"}, BW'(in_ready), BW'(q.size() < 2));
  endtask

  task automatic offer(input logic [LANES-1:0] v, input logic [BW-1:0] p);
    in_valid   = v;
    in_payload = p;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(2'b11, bundle2(PW'('h11), PW'('h22)));
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
    offer(2'b00, '0);
    cycle("post_rst");
    check("post_rst_ready_const", BW'(in_ready), BW'(1));

    // Streaming A, B, C with downstream always ready.
    out_ready = 1'b1;
    offer(2'b11, bundle2(PW'('h11), PW'('h22))); cycle("strA");
    check("strA_lane0", BW'(out_payload[PW-1:0]), BW'('h11));
    offer(2'b11, bundle2(PW'('h33), PW'('h44))); cycle("strB");
    offer(2'b11, bundle2(PW'('h55), PW'('h66))); cycle("strC");
    offer(2'b00, '0); cycle("strD0"); cycle("strD1");

    // Backpressure: fill both entries, try a third, then drain.
    out_ready = 1'b0;
    offer(2'b11, bundle2(PW'('hA1), PW'('hA2))); cycle("bpA");
    offer(2'b11, bundle2(PW'('hB1), PW'('hB2))); cycle("bpB");
    offer(2'b11, bundle2(PW'('hC1), PW'('hC2))); cycle("bpFull");
    check("bp_occ2", BW'(occupancy), BW'(2));
    offer(2'b00, '0);
    out_ready = 1'b1;
    cycle("drain0"); cycle("drain1"); cycle("drain2");

    // Flush at occupancy 2 while offering D.
    out_ready = 1'b0;
    offer(2'b11, bundle2(PW'('h1), PW'('h2))); cycle("flA");
    offer(2'b11, bundle2(PW'('h3), PW'('h4))); cycle("flB");
    flush = 1'b1;
    offer(2'b11, bundle2(PW'('hD1), PW'('hD2))); cycle("flush");
    flush = 1'b0;
    offer(2'b00, '0); out_ready = 1'b1; cycle("post_flush");

    // Partial bundle, then a bubble while held.
    out_ready = 1'b0;
    offer(2'b10, bundle2(PW'('h777), PW'('hABC))); cycle("partial");
    check("partial_lane1", BW'(out_payload[BW-1:PW]), BW'('hABC));
    offer(2'b00, bundle2(PW'('h5), PW'('h6))); cycle("bubble");
    out_ready = 1'b1; cycle("partial_drain");

    // rst and flush together at occupancy 2.
    out_ready = 1'b0;
    offer(2'b11, bundle2(PW'('hE1), PW'('hE2))); cycle("prA");
    offer(2'b11, bundle2(PW'('hF1), PW'('hF2))); cycle("prB");
    rst = 1'b1; flush = 1'b1; cycle("rst_flush");
    check("rst_flush_payload", out_payload, '0);
    rst = 1'b0; flush = 1'b0; offer(2'b00, '0); cycle("post_prio");

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      offer(LANES'($urandom_range(0, 3)), bundle2(rnd_lane(), rnd_lane()));
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
